// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter: burst-aware round-robin owner of a slave-port payload mux select (optional AHB_ARB_LOCK_EN keeps locked owners).
// Latency: a decision taken at edge N appears on sel/owner_idx/busy after edge N; all outputs are registered.
// Backpressure: hready=0 freezes beat counting and arbitration; the grant only moves at transfer boundaries.
module ahb_slave_port_arbiter #(
    parameter int CHANNEL_NUM = 4,
    parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [CHANNEL_NUM-1:0] hmastlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [CHANNEL_NUM-1:0] sel,
    output logic [IDX_W-1:0]       owner_idx,
    output logic                   busy
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [3:0]             beat_cnt;

    logic                   burst_fixed;
    logic [3:0]             burst_reload;
    logic [CHANNEL_NUM-1:0] req_rot;
    logic                   win_vld;
    logic [IDX_W-1:0]       win_off;
    logic [IDX_W:0]         win_sum;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       win_next_ptr;
    logic [CHANNEL_NUM-1:0] win_sel;
    logic                   at_ap;
    logic                   lock_keep;

    // Fixed-length burst decode: remaining SEQ beats after the NONSEQ beat.
    always_comb begin
        burst_fixed  = |hburst[2:1];
        burst_reload = 4'd0;
        case (hburst[2:1])
            2'b01:   burst_reload = 4'd3;
            2'b10:   burst_reload = 4'd7;
            2'b11:   burst_reload = 4'd15;
            default: burst_reload = 4'd0;
        endcase
    end

    // Rotate requests so bit 0 is the highest-priority master (the one at rr_ptr).
    assign req_rot = CHANNEL_NUM'({req, req} >> rr_ptr);

    // Lowest set bit of the rotated vector is the winner's distance from rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_off = '0;
        for (int k = CHANNEL_NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_vld = 1'b1;
                win_off = IDX_W'(k);
            end
        end
    end

    // Map the offset back to an absolute index modulo CHANNEL_NUM (not necessarily a power of two).
    always_comb begin
        win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
        if (win_sum >= (IDX_W+1)'(CHANNEL_NUM)) begin
            win_idx = IDX_W'(win_sum - (IDX_W+1)'(CHANNEL_NUM));
        end else begin
            win_idx = IDX_W'(win_sum);
        end
        if (win_idx == IDX_W'(CHANNEL_NUM - 1)) begin
            win_next_ptr = '0;
        end else begin
            win_next_ptr = win_idx + IDX_W'(1);
        end
        win_sel = CHANNEL_NUM'(1) << win_idx;
    end

    // Arbitration point: the only cycles where ownership may change hands.
    always_comb begin
        at_ap = 1'b0;
        case (state)
            ST_IDLE:  at_ap = |req;
            ST_OWN:   at_ap = hready && ((htrans == TR_IDLE) ||
                                         ((htrans == TR_NONSEQ) && (hburst == HB_SINGLE)));
            ST_BURST: at_ap = hready && (htrans == TR_SEQ) && (beat_cnt == 4'd1);
            default:  at_ap = 1'b0;
        endcase
    end

`ifdef AHB_ARB_LOCK_EN
    // A locked owner keeps the port across arbitration points.
    assign lock_keep = (state != ST_IDLE) && hmastlock[owner_idx];
`else
    logic unused_hmastlock;
    assign unused_hmastlock = ^hmastlock;
    assign lock_keep        = 1'b0;
`endif

    // Grant FSM: registered sel/owner_idx/busy, round-robin pointer and burst beat counter.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            sel       <= '0;
            owner_idx <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else if (at_ap) begin
            beat_cnt <= '0;
            if (lock_keep) begin
                state <= ST_OWN;
            end else if (win_vld) begin
                state     <= ST_OWN;
                sel       <= win_sel;
                owner_idx <= win_idx;
                busy      <= 1'b1;
                rr_ptr    <= win_next_ptr;
            end else begin
                state     <= ST_IDLE;
                sel       <= '0;
                owner_idx <= '0;
                busy      <= 1'b0;
            end
        end else begin
            case (state)
                ST_OWN: begin
                    if (hready && (htrans == TR_NONSEQ) && burst_fixed) begin
                        state    <= ST_BURST;
                        beat_cnt <= burst_reload;
                    end
                end
                ST_BURST: begin
                    if (hready && (htrans == TR_NONSEQ)) begin
                        // Early termination: restart as if a fresh transfer began in OWN.
                        beat_cnt <= burst_reload;
                        state    <= burst_fixed ? ST_BURST : ST_OWN;
                    end else if (hready && (htrans == TR_SEQ)) begin
                        beat_cnt <= beat_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// tb_ahb_slave_port_arbiter: directed scenarios for the burst-aware round-robin slave port arbiter.
// Latency: checks sample 1 time unit after each rising edge, inputs change at the same point.
// Backpressure: exercises hready=0 and BUSY insertion inside a fixed-length burst.
module tb_ahb_slave_port_arbiter;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_INCR8  = 3'b101;
    localparam logic [2:0] HB_INCR16 = 3'b111;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req;
    logic [3:0] hmastlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] sel;
    logic [1:0] owner_idx;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_slave_port_arbiter #(.CHANNEL_NUM(4)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req),
        .hmastlock (hmastlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .sel       (sel),
        .owner_idx (owner_idx),
        .busy      (busy)
    );

    always #5 HCLK = ~HCLK;

    // Structural invariants checked on every falling edge.
    always @(negedge HCLK) begin
        n_cmp++;
        if (!$onehot0(sel)) begin
            $display("FAIL onehot0_sel: got %b want at most one bit set", sel);
            n_bad++;
        end
        n_cmp++;
        if (busy !== (|sel)) begin
            $display("FAIL busy_vs_sel: got busy=%b want %b (sel=%b)", busy, |sel, sel);
            n_bad++;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [2:0] hb, input logic rdy);
        htrans = tr;
        hburst = hb;
        hready = rdy;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        req = 4'b1111;
        hmastlock = 4'b0000;
        drive(TR_IDLE, HB_SINGLE, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if (sel !== 4'b0000) begin $display("FAIL reset_sel: got %b want %b", sel, 4'b0000); n_bad++; end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want %b", busy, 1'b0); n_bad++; end
        n_cmp++;
        if (owner_idx !== 2'd0) begin $display("FAIL reset_owner: got %0d want %0d", owner_idx, 0); n_bad++; end
        HRESETn = 1'b1;
        tick();
        n_cmp++;
        if (sel !== 4'b0001) begin $display("FAIL reset_release_sel: got %b want %b", sel, 4'b0001); n_bad++; end
        n_cmp++;
        if (busy !== 1'b1) begin $display("FAIL reset_release_busy: got %b want %b", busy, 1'b1); n_bad++; end
    endtask

    // Owner 0, rr_ptr 1 on entry; SINGLE transfers rotate the grant.
    task automatic test_round_robin();
        logic [3:0] exp_sel [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'b1111;
        drive(TR_NONSEQ, HB_SINGLE, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (sel !== exp_sel[i]) begin $display("FAIL rr_sel[%0d]: got %b want %b", i, sel, exp_sel[i]); n_bad++; end
            n_cmp++;
            if (owner_idx !== exp_idx[i]) begin $display("FAIL rr_owner[%0d]: got %0d want %0d", i, owner_idx, exp_idx[i]); n_bad++; end
        end
    endtask

    // Owner 0, rr_ptr 1 on entry; two SINGLE APs hand the port to master 2.
    task automatic test_incr8_burst();
        logic [1:0] tr_v  [12] = '{TR_SEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ,
                                   TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ, TR_SEQ};
        logic       rdy_v [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] want;
        req = 4'b1111;
        drive(TR_NONSEQ, HB_SINGLE, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (sel !== 4'b0100) begin $display("FAIL incr8_setup_sel: got %b want %b", sel, 4'b0100); n_bad++; end
        drive(TR_NONSEQ, HB_INCR8, 1'b1);
        tick();
        n_cmp++;
        if (sel !== 4'b0100) begin $display("FAIL incr8_nonseq_sel: got %b want %b", sel, 4'b0100); n_bad++; end
        for (int i = 0; i < 12; i++) begin
            drive(tr_v[i], HB_INCR8, rdy_v[i]);
            tick();
            want = (i == 11) ? 4'b1000 : 4'b0100;
            n_cmp++;
            if (sel !== want) begin $display("FAIL incr8_sel[%0d]: got %b want %b", i, sel, want); n_bad++; end
        end
    endtask

    // Owner 3, rr_ptr 0 on entry; master 1 wins alone, then idles with no requesters.
    task automatic test_idle_release();
        req = 4'b0010;
        drive(TR_NONSEQ, HB_SINGLE, 1'b1);
        tick();
        n_cmp++;
        if (sel !== 4'b0010) begin $display("FAIL idle_grant_sel: got %b want %b", sel, 4'b0010); n_bad++; end
        n_cmp++;
        if (owner_idx !== 2'd1) begin $display("FAIL idle_grant_owner: got %0d want %0d", owner_idx, 1); n_bad++; end
        req = 4'b0000;
        drive(TR_IDLE, HB_SINGLE, 1'b1);
        tick();
        n_cmp++;
        if (sel !== 4'b0000) begin $display("FAIL idle_release_sel: got %b want %b", sel, 4'b0000); n_bad++; end
        n_cmp++;
        if (owner_idx !== 2'd0) begin $display("FAIL idle_release_owner: got %0d want %0d", owner_idx, 0); n_bad++; end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL idle_release_busy: got %b want %b", busy, 1'b0); n_bad++; end
        tick();
        n_cmp++;
        if (sel !== 4'b0000) begin $display("FAIL idle_stay_sel: got %b want %b", sel, 4'b0000); n_bad++; end
    endtask

    // IDLE, rr_ptr 2 on entry; master 0 takes the port, then two SINGLE APs with it locked.
    task automatic test_lock();
        logic [3:0] exp_sel [2];
`ifdef AHB_ARB_LOCK_EN
        exp_sel = '{4'b0001, 4'b0001};
`else
        exp_sel = '{4'b0010, 4'b0001};
`endif
        req = 4'b0001;
        drive(TR_IDLE, HB_SINGLE, 1'b1);
        tick();
        n_cmp++;
        if (sel !== 4'b0001) begin $display("FAIL lock_grant_sel: got %b want %b", sel, 4'b0001); n_bad++; end
        req = 4'b0011;
        hmastlock = 4'b0001;
        drive(TR_NONSEQ, HB_SINGLE, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (sel !== exp_sel[i]) begin $display("FAIL lock_sel[%0d]: got %b want %b", i, sel, exp_sel[i]); n_bad++; end
        end
        hmastlock = 4'b0000;
    endtask

    // Owner 0, rr_ptr 1 on entry; a NONSEQ mid-INCR4 reloads the beat counter.
    task automatic test_early_term();
        logic [1:0] tr_v [5] = '{TR_SEQ, TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ};
        logic [3:0] want;
        req = 4'b1111;
        drive(TR_NONSEQ, HB_INCR4, 1'b1);
        tick();
        n_cmp++;
        if (sel !== 4'b0001) begin $display("FAIL early_nonseq_sel: got %b want %b", sel, 4'b0001); n_bad++; end
        for (int i = 0; i < 5; i++) begin
            drive(tr_v[i], HB_INCR4, 1'b1);
            tick();
            want = (i == 4) ? 4'b0010 : 4'b0001;
            n_cmp++;
            if (sel !== want) begin $display("FAIL early_sel[%0d]: got %b want %b", i, sel, want); n_bad++; end
        end
    endtask

    // Owner 1, rr_ptr 2 on entry; reset lands on INCR16 beat 5 and clears everything.
    task automatic test_reset_mid_burst();
        req = 4'b1111;
        drive(TR_NONSEQ, HB_INCR16, 1'b1);
        tick();
        drive(TR_SEQ, HB_INCR16, 1'b1);
        repeat (3) tick();
        n_cmp++;
        if (sel !== 4'b0010) begin $display("FAIL midrst_pre_sel: got %b want %b", sel, 4'b0010); n_bad++; end
        HRESETn = 1'b0;
        tick();
        n_cmp++;
        if (sel !== 4'b0000) begin $display("FAIL midrst_sel: got %b want %b", sel, 4'b0000); n_bad++; end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want %b", busy, 1'b0); n_bad++; end
        HRESETn = 1'b1;
        req = 4'b0000;
        repeat (3) tick();
        n_cmp++;
        if (sel !== 4'b0000) begin $display("FAIL midrst_no_resume_sel: got %b want %b", sel, 4'b0000); n_bad++; end
        req = 4'b1111;
        tick();
        n_cmp++;
        if (sel !== 4'b0001) begin $display("FAIL midrst_regrant_sel: got %b want %b", sel, 4'b0001); n_bad++; end
        tick();
        n_cmp++;
        if (sel !== 4'b0001) begin $display("FAIL midrst_seq_hold_sel: got %b want %b", sel, 4'b0001); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_incr8_burst();
        test_idle_release();
        test_lock();
        test_early_term();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
